// File: rtl/mix_add_round_seq.sv
// Column-serial AES MixColumns + AddRoundKey stage: one 32-bit column per cycle,
// valid/ready handshakes on both sides, MixColumns bypass for the final round.
module mix_add_round_seq #(
  parameter bit ADD_KEY = 1'b1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_state,
  input  logic [127:0] in_key,
  input  logic         in_last,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_state,
  output logic         busy
);

  // state    | meaning
  // ST_IDLE  | waiting for a block, in_ready high
  // ST_MIX   | processing column r_col (0..3), one per cycle
  // ST_DONE  | result held on out_state until out_ready
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MIX  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t       r_fsm;
  logic [1:0]   r_col;
  logic [127:0] r_state;
  logic [127:0] r_key;
  logic         r_last;
  logic [127:0] r_out_state;
  logic         r_out_valid;
  logic         r_busy;

  logic         w_accept;
  logic [31:0]  w_col_a;
  logic [31:0]  w_col_k;
  logic [31:0]  w_col_m;
  logic [31:0]  w_col_r;

  function automatic logic [7:0] xtime(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1B : 8'h00);
  endfunction

  function automatic logic [31:0] mix_col(input logic [31:0] a);
    logic [7:0] a0, a1, a2, a3;
    logic [7:0] b0, b1, b2, b3;
    a0 = a[31:24];
    a1 = a[23:16];
    a2 = a[15:8];
    a3 = a[7:0];
    // 3x = 2x ^ x
    b0 = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
    b1 = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
    b2 = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
    b3 = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
    return {b0, b1, b2, b3};
  endfunction

  assign in_ready  = !rst && ((r_fsm == ST_IDLE) || ((r_fsm == ST_DONE) && out_ready));
  assign w_accept  = in_valid && in_ready;
  assign out_state = r_out_state;
  assign out_valid = r_out_valid;
  assign busy      = r_busy;

  always_comb begin
    w_col_a = r_state[127:96];
    w_col_k = r_key[127:96];
    case (r_col)
      2'd0: begin w_col_a = r_state[127:96]; w_col_k = r_key[127:96]; end
      2'd1: begin w_col_a = r_state[95:64];  w_col_k = r_key[95:64];  end
      2'd2: begin w_col_a = r_state[63:32];  w_col_k = r_key[63:32];  end
      default: begin w_col_a = r_state[31:0]; w_col_k = r_key[31:0]; end
    endcase
  end

  assign w_col_m = r_last ? w_col_a : mix_col(w_col_a);
  assign w_col_r = ADD_KEY ? (w_col_m ^ w_col_k) : w_col_m;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_fsm       <= ST_IDLE;
      r_col       <= 2'd0;
      r_state     <= '0;
      r_key       <= '0;
      r_last      <= 1'b0;
      r_out_state <= '0;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      case (r_fsm)
        ST_IDLE: begin
          if (w_accept) begin
            r_state <= in_state;
            r_key   <= in_key;
            r_last  <= in_last;
            r_col   <= 2'd0;
            r_fsm   <= ST_MIX;
            r_busy  <= 1'b1;
          end
        end
        ST_MIX: begin
          case (r_col)
            2'd0:    r_out_state[127:96] <= w_col_r;
            2'd1:    r_out_state[95:64]  <= w_col_r;
            2'd2:    r_out_state[63:32]  <= w_col_r;
            default: r_out_state[31:0]   <= w_col_r;
          endcase
          r_col <= r_col + 2'd1;
          if (r_col == 2'd3) begin
            r_fsm       <= ST_DONE;
            r_out_valid <= 1'b1;
          end
        end
        ST_DONE: begin
          // Retire and accept on the same edge so back-to-back blocks see no bubble.
          if (w_accept) begin
            r_state     <= in_state;
            r_key       <= in_key;
            r_last      <= in_last;
            r_col       <= 2'd0;
            r_fsm       <= ST_MIX;
            r_out_valid <= 1'b0;
          end else if (out_ready) begin
            r_fsm       <= ST_IDLE;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
          end
        end
        default: begin
          r_fsm       <= ST_IDLE;
          r_out_valid <= 1'b0;
          r_busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mix_add_round_seq.sv
// Bench for mix_add_round_seq: directed vector table, hand-written handshake/reset
// sequences and random blocks against a GF(2^8) matrix reference model.
module tb_mix_add_round_seq;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_state;
  logic [127:0] in_key;
  logic         in_last;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_state;
  logic         busy;
  logic         nk_in_ready;
  logic         nk_out_valid;
  logic [127:0] nk_out_state;
  logic         nk_busy;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  mix_add_round_seq #(.ADD_KEY(1'b1)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_state(in_state), .in_key(in_key), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_state(out_state), .busy(busy)
  );

  mix_add_round_seq #(.ADD_KEY(1'b0)) dut_nk (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(nk_in_ready),
    .in_state(in_state), .in_key(in_key), .in_last(in_last),
    .out_valid(nk_out_valid), .out_ready(out_ready), .out_state(nk_out_state), .busy(nk_busy)
  );

  typedef struct {
    logic [127:0] st;
    logic [127:0] key;
    logic         last;
    logic [127:0] exp;
    logic [127:0] exp_nk;
  } vec_t;

  vec_t vecs[4];

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [8:0] aa;
    logic [7:0] p;
    p  = 8'h00;
    aa = {1'b0, a};
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa[7:0];
      aa = aa << 1;
      if (aa[8]) aa = aa ^ 9'h11B;
    end
    return p;
  endfunction

  function automatic logic [127:0] ref_round(input logic [127:0] s, input logic [127:0] k,
                                             input logic last, input logic add_key);
    logic [7:0] m[4][4];
    logic [7:0] a[4];
    logic [7:0] b;
    logic [127:0] r;
    m[0] = '{8'd2, 8'd3, 8'd1, 8'd1};
    m[1] = '{8'd1, 8'd2, 8'd3, 8'd1};
    m[2] = '{8'd1, 8'd1, 8'd2, 8'd3};
    m[3] = '{8'd3, 8'd1, 8'd1, 8'd2};
    r = '0;
    for (int c = 0; c < 4; c++) begin
      for (int i = 0; i < 4; i++) a[i] = s[127 - 32*c - 8*i -: 8];
      for (int i = 0; i < 4; i++) begin
        if (last) b = a[i];
        else begin
          b = 8'h00;
          for (int j = 0; j < 4; j++) b = b ^ gf_mul(m[i][j], a[j]);
        end
        if (add_key) b = b ^ k[127 - 32*c - 8*i -: 8];
        r[127 - 32*c - 8*i -: 8] = b;
      end
    end
    return r;
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive a block, wait for accept, then wait out the latency; leaves DUT in DONE.
  task automatic send_and_wait(input logic [127:0] s, input logic [127:0] k, input logic l,
                               input string name);
    int n;
    in_state = s; in_key = k; in_last = l; in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 20) begin tick(); n++; end
    chk({name, " accept_ready"}, 128'(in_ready), 128'd1);
    tick();
    in_valid = 1'b0;
    in_state = $urandom; in_key = $urandom; in_last = 1'($urandom);
    n = 0;
    while (!out_valid && n < 20) begin tick(); n++; end
    chk({name, " latency"}, 128'(n), 128'd4);
  endtask

  task automatic retire();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  logic [127:0] held;
  logic [127:0] exp_r;
  int           stall;

  initial begin
    vecs[0] = '{128'hd4bf5d30e0b452aeb84111f11e2798e5, 128'ha0fafe1788542cb123a339392a6c7605, 1'b0,
                128'ha49c7ff2689f352b6b5bea43026a5049, 128'h046681e5e0cb199a48f8d37a2806264c};
    vecs[1] = '{128'hdb135345f20a225c010101012d26314c, 128'h0, 1'b0,
                128'h8e4da1bc9fdc589d010101014d7ebdf8, 128'h8e4da1bc9fdc589d010101014d7ebdf8};
    vecs[2] = '{128'hdb135345f20a225c010101012d26314c, {128{1'b1}}, 1'b0,
                ~128'h8e4da1bc9fdc589d010101014d7ebdf8, 128'h8e4da1bc9fdc589d010101014d7ebdf8};
    vecs[3] = '{128'h00112233445566778899aabbccddeeff, 128'h0, 1'b1,
                128'h00112233445566778899aabbccddeeff, 128'h00112233445566778899aabbccddeeff};

    rst = 1'b1; in_valid = 1'b0; in_state = '0; in_key = '0; in_last = 1'b0; out_ready = 1'b0;
    #3;
    chk("rst in_ready", 128'(in_ready), 128'd0);
    chk("rst out_valid", 128'(out_valid), 128'd0);
    chk("rst busy", 128'(busy), 128'd0);
    chk("rst out_state", out_state, 128'd0);
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    tick();
    chk("idle in_ready", 128'(in_ready), 128'd1);

    // Directed vectors
    foreach (vecs[i]) begin
      send_and_wait(vecs[i].st, vecs[i].key, vecs[i].last, $sformatf("vec%0d", i));
      chk($sformatf("vec%0d out_state", i), out_state, vecs[i].exp);
      chk($sformatf("vec%0d nokey out_state", i), nk_out_state, vecs[i].exp_nk);
      chk($sformatf("vec%0d model", i), vecs[i].exp,
          ref_round(vecs[i].st, vecs[i].key, vecs[i].last, 1'b1));
      retire();
      chk($sformatf("vec%0d retired", i), {126'd0, out_valid, busy}, 128'd0);
    end

    // Back-pressure then same-edge handoff
    send_and_wait(vecs[0].st, vecs[0].key, 1'b0, "bp");
    held = out_state;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("bp stable", out_state, held);
      chk("bp flags", {125'd0, out_valid, in_ready, busy}, 128'b101);
    end
    in_state = vecs[1].st; in_key = vecs[1].key; in_last = 1'b0; in_valid = 1'b1;
    out_ready = 1'b1;
    #1;
    chk("handoff in_ready", 128'(in_ready), 128'd1);
    tick();
    in_valid = 1'b0;
    chk("handoff no bubble", {126'd0, out_valid, busy}, 128'b01);
    for (int i = 0; i < 3; i++) tick();
    chk("handoff col3 not valid", 128'(out_valid), 128'd0);
    tick();
    chk("handoff latency", 128'(out_valid), 128'd1);
    chk("handoff result", out_state, vecs[1].exp);
    tick();
    out_ready = 1'b0;
    chk("handoff retired", 128'(out_valid), 128'd0);

    // Reset mid-MIX at col 2
    in_state = vecs[1].st; in_key = vecs[1].key; in_last = 1'b0; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick(); tick();
    rst = 1'b1;
    #1;
    chk("midrst out_valid", 128'(out_valid), 128'd0);
    chk("midrst out_state", out_state, 128'd0);
    chk("midrst busy", 128'(busy), 128'd0);
    chk("midrst in_ready", 128'(in_ready), 128'd0);
    @(negedge clk);
    rst = 1'b0;
    tick();
    chk("postrst in_ready", 128'(in_ready), 128'd1);
    for (int i = 0; i < 6; i++) begin
      tick();
      tests++;
      if (out_valid) begin fails++; $display("FAIL postrst stray out_valid got 1 expected 0"); end
    end
    send_and_wait(vecs[0].st, vecs[0].key, 1'b0, "postrst");
    chk("postrst result", out_state, vecs[0].exp);
    retire();

    // Random blocks against the matrix model
    for (int t = 0; t < 40; t++) begin
      logic [127:0] s, k;
      logic l;
      s = {$urandom, $urandom, $urandom, $urandom};
      k = {$urandom, $urandom, $urandom, $urandom};
      l = ($urandom_range(0, 3) == 0);
      stall = $urandom_range(0, 3);
      send_and_wait(s, k, l, $sformatf("rnd%0d", t));
      exp_r = ref_round(s, k, l, 1'b1);
      chk($sformatf("rnd%0d out_state", t), out_state, exp_r);
      chk($sformatf("rnd%0d nokey", t), nk_out_state, ref_round(s, k, l, 1'b0));
      for (int i = 0; i < stall; i++) begin
        tick();
        chk($sformatf("rnd%0d hold", t), out_state, exp_r);
      end
      retire();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
